// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and default sizes for mem_arbiter.
// Holds the owner tag, the lock state and the default ADDR_W/DATA_W/STARVE_MAX values.
package mem_arbiter_pkg;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;
endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: fetch starvation counter with threshold compare.
// Ports: clk, rst (async active-low), if_req/if_gnt (fetch request and grant), starved (count >= STARVE_MAX).
// Only instantiated when MEM_ARBITER_ANTISTARVE_EN is defined.
module mem_arb_starve
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic starved
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!if_req || if_gnt)
            cnt <= '0;
        else if (cnt != 4'hF)
            cnt <= cnt + 4'd1;
    end

    assign starved = cnt >= 4'(STARVE_MAX);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-port synchronous memory.
// Ports: clk, rst (async active-low); if_req/if_addr -> if_gnt, if_rvalid/if_rdata (fetch reads);
//        dm_req/dm_we/dm_addr/dm_wdata/dm_lock -> dm_gnt, dm_rvalid/dm_rdata (data port, atomic pairs);
//        mem_en/mem_we/mem_addr/mem_wdata memory command, mem_rdata read return.
// Build option MEM_ARBITER_ANTISTARVE_EN: fetch overrides dm after STARVE_MAX denied cycles (not while locked).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_lock,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    lock_t  state, state_nxt;
    owner_t owner;
    logic   locked;
    logic   starved;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_arbiter: STARVE_MAX must be 1..15");
    end

`ifdef MEM_ARBITER_ANTISTARVE_EN
    mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .starved (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Grants are gated by rst so every command output is quiet during reset.
    always_comb begin
        if_gnt    = rst && if_req && (!dm_req || (starved && !locked));
        dm_gnt    = rst && dm_req && !if_gnt;
        mem_en    = if_gnt || dm_gnt;
        mem_we    = dm_gnt && dm_we;
        mem_addr  = dm_gnt ? dm_addr : if_gnt ? if_addr : '0;
        mem_wdata = dm_gnt ? dm_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= UNLOCKED;
        else
            state <= state_nxt;
    end

    // A locked read holds the lock until its write is granted or the data port lets go.
    always_comb begin
        state_nxt = (state == UNLOCKED)
                  ? ((dm_gnt && dm_lock && !dm_we) ? LOCKED : UNLOCKED)
                  : (((dm_gnt && dm_we) || !dm_req || !dm_lock) ? UNLOCKED : LOCKED);
    end

    always_comb begin
        locked = state == LOCKED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            owner <= OWN_NONE;
        else
            owner <= if_gnt ? OWN_IF : (dm_gnt && !dm_we) ? OWN_DM : OWN_NONE;
    end

    assign if_rvalid = owner == OWN_IF;
    assign dm_rvalid = owner == OWN_DM;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (expectations follow MEM_ARBITER_ANTISTARVE_EN).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_lock, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend = '0;
    logic        exp_if;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_lock   (dm_lock),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
        check({tag, ".dm_gnt"},    32'(dm_gnt),    32'd0);
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'd0);
        check({tag, ".mem_en"},    32'(mem_en),    32'd0);
        check({tag, ".mem_we"},    32'(mem_we),    32'd0);
        check({tag, ".mem_addr"},  mem_addr,       32'd0);
        check({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    endtask

    // One clock cycle: drive, check last cycle's read return, check grants and command, queue new reads.
    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic dl, input logic [31:0] da, input logic [31:0] dd,
                       input logic [31:0] rd, input logic ei, input logic ed);
        exp_t e;
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_lock = dl; dm_addr = da; dm_wdata = dd;
        mem_rdata = pend;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("if_rvalid", 32'(if_rvalid), 32'(e.own == 2'd1));
            check("dm_rvalid", 32'(dm_rvalid), 32'(e.own == 2'd2));
            check(e.own == 2'd1 ? "if_rdata" : "dm_rdata", e.own == 2'd1 ? if_rdata : dm_rdata, e.data);
        end else begin
            check("if_rvalid_idle", 32'(if_rvalid), 32'd0);
            check("dm_rvalid_idle", 32'(dm_rvalid), 32'd0);
        end
        check("if_gnt",    32'(if_gnt),  32'(ei));
        check("dm_gnt",    32'(dm_gnt),  32'(ed));
        check("mem_en",    32'(mem_en),  32'(ei | ed));
        check("mem_we",    32'(mem_we),  32'(ed & dw));
        check("mem_addr",  mem_addr,     ed ? da : ei ? ia : 32'd0);
        check("mem_wdata", mem_wdata,    ed ? dd : 32'd0);
        if (ei)
            sb.push_back('{2'd1, rd});
        else if (ed && !dw)
            sb.push_back('{2'd2, rd});
        pend = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_lock = 0;
        dm_addr = 32'h20; dm_wdata = 32'h30; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1;

        // Lone fetch read, data returned next cycle.
        cyc(1, 32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0);
        // Fetch and data write together: data wins, no read return.
        cyc(1, 32'h104, 1, 1, 0, 32'h200, 32'h12345678, $urandom, 0, 1);
        idle();
        // Lone data read.
        cyc(0, 0, 1, 0, 0, 32'h40, 0, 32'hA5A55A5A, 0, 1);
        idle();

        // Both ports requesting for 20 cycles.
        for (int i = 0; i < 20; i++) begin
`ifdef MEM_ARBITER_ANTISTARVE_EN
            exp_if = (i % 5) == 4;
`else
            exp_if = 1'b0;
`endif
            cyc(1, 32'h1000 + i, 1, i[0], 0, 32'h2000 + i, $urandom, $urandom, exp_if, !exp_if);
        end
        idle();

        // Locked read-read-write while fetch builds up starvation.
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h500, 1, 1, 0, 32'h600 + i, $urandom, 0, 0, 1);
        cyc(1, 32'h500, 1, 0, 1, 32'h300, 0, $urandom, 0, 1);
        cyc(1, 32'h500, 1, 0, 1, 32'h300, 0, $urandom, 0, 1);
        cyc(1, 32'h500, 1, 1, 1, 32'h300, 32'hCAFEF00D, 0, 0, 1);
`ifdef MEM_ARBITER_ANTISTARVE_EN
        exp_if = 1'b1;
`else
        exp_if = 1'b0;
`endif
        cyc(1, 32'h500, 1, 1, 0, 32'h700, 32'h77, $urandom, exp_if, !exp_if);
        idle();

        // Reset with a fetch read in flight.
        cyc(1, 32'h800, 0, 0, 0, 0, 0, $urandom, 1, 0);
        if_req = 1; dm_req = 1;
        rst = 0;
        #1;
        chk_zero("rst_inflight");
        sb.delete();
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1;
        idle();
        cyc(1, 32'h900, 0, 0, 0, 0, 0, 32'h13579BDF, 1, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports.
REQ-003 Parameter STARVE_MAX, default 4, consecutive denied fetch cycles before a forced fetch grant; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req / if_addr  input  1 / ADDR_W  instruction-fetch read request and address.
REQ-007 if_gnt  output  1  fetch granted this cycle.
REQ-008 if_rvalid / if_rdata  output  1 / DATA_W  fetch read data valid, one cycle after if_gnt.
REQ-009 dm_req / dm_we / dm_addr / dm_wdata  input  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, address, write data.
REQ-010 dm_lock  input  1  data port requests an atomic read-then-write pair.
REQ-011 dm_gnt  output  1  data port granted this cycle.
REQ-012 dm_rvalid / dm_rdata  output  1 / DATA_W  data read valid, one cycle after a granted read.
REQ-013 mem_en / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / DATA_W  single-port synchronous memory command.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid the cycle after a read command.

Function
REQ-015 At most one of if_gnt, dm_gnt SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-016 Default priority: dm_req wins over if_req.
REQ-017 Granted port's addr/we/wdata SHALL drive mem_*; mem_en equals (if_gnt | dm_gnt); fetch grants drive mem_we = 0.
REQ-018 No grant: mem_en = 0, mem_we = 0, mem_addr/mem_wdata = 0.
REQ-019 A granted read SHALL set a registered owner tag; next cycle exactly the owner's rvalid goes high for one cycle; granted writes produce no rvalid.
REQ-020 if_rdata and dm_rdata SHALL both carry mem_rdata unconditionally; consumers qualify with rvalid.
REQ-021 Lock FSM states UNLOCKED, LOCKED: UNLOCKED -> LOCKED when dm_gnt with dm_lock=1 and dm_we=0; LOCKED forces dm priority over everything including the starvation override; LOCKED -> UNLOCKED after any dm_gnt with dm_we=1, or any cycle with dm_req=0 or dm_lock=0.
REQ-022 Simultaneous if_req and dm_req with neither starvation nor lock active: dm granted, fetch denied.

Reset
REQ-023 While rst low: if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; lock FSM UNLOCKED; starvation counter 0; owner tag cleared.
REQ-024 Reset asserted with a read in flight SHALL discard it: no rvalid in the cycle after release.
REQ-025 First grant possible in the first posedge-bounded cycle after rst rises.

Configuration
REQ-026 Macro MEM_ARBITER_ANTISTARVE_EN defined: 4-bit counter increments each cycle if_req=1 and if_gnt=0, clears on if_gnt or if_req=0, saturates at 15; when counter >= STARVE_MAX and FSM UNLOCKED, fetch SHALL win over dm.
REQ-027 Macro undefined: no counter; strict dm priority per REQ-016 and REQ-021.

Structure
REQ-028 Shared package SHALL hold owner-tag encoding (OWN_NONE, OWN_IF, OWN_DM), lock-state encoding, and default ADDR_W/DATA_W/STARVE_MAX constants.
REQ-029 Sub-module mem_arb_starve (counter + threshold compare) SHALL be instantiated only under MEM_ARBITER_ANTISTARVE_EN; all other logic inline.

Verification
REQ-030 if_req=1, if_addr=0x100, dm_req=0, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1, mem_addr=0x100, mem_we=0; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, dm_rvalid=0.
REQ-031 if_req=1 and dm_req=1 write 0x200<-0x12345678 same cycle -> dm_gnt=1, mem_we=1, mem_wdata=0x12345678, if_gnt=0; no rvalid next cycle.
REQ-032 ANTISTARVE_EN, STARVE_MAX=4, both requesting continuously -> dm granted cycles 0-3, if_gnt=1 in cycle 4, counter 0 and dm granted in cycle 5.
REQ-033 dm_lock=1 read 0x300, then dm_lock=1 write 0x300 with if starved (counter=4) -> dm_gnt both cycles; if_gnt in the cycle after the write.
REQ-034 Read granted, rst pulled low before next posedge and released -> if_rvalid/dm_rvalid stay 0; all outputs 0 during reset.
REQ-035 Macro undefined, both requesting 20 cycles -> dm_gnt=1 all 20 cycles, if_gnt never asserted.
